dispense_timer: RTL and testbench

- Timing back-end for the pet food dispenser controller.
- Consumes the 2-bit command code driven by the Moore controller FSM and returns the 16-bit remaining-count value `cont` that the FSM monitors for expiry.
- Sequences the feed interval and the dispense duration on a prescaled tick.
- Generates the motor step waveform while dispensing.

---
 rtl/dispenser_pkg.sv | 16 +
 rtl/tick_prescaler.sv | 28 ++
 rtl/dispense_timer.sv | 107 ++++++++++
 tb/tb_dispense_timer.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/dispenser_pkg.sv
// Shared definitions for the pet food dispenser controller and its timing back-end.
// Command codes, timer state encoding and count width.
package dispenser_pkg;
  localparam int CONT_W = 16;

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_WAIT  = 2'b01;
  localparam logic [1:0] CMD_DISP  = 2'b10;
  localparam logic [1:0] CMD_FAULT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COUNT   = 2'b01,
    ST_EXPIRED = 2'b10
  } state_t;
endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..PRESC-1 divider; tick is combinational in the last count cycle while en.
// Latency: first tick PRESC clocks after clr; no backpressure, clr wins over en.
module tick_prescaler #(
  parameter int PRESC = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int W = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [W-1:0] LAST = W'(PRESC - 1);

  logic [W-1:0] cnt_q;

  assign tick = en && (cnt_q == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/dispense_timer.sv
// Feed-interval / dispense-duration timer with motor step generation; loads on any cmd change,
// outputs valid one clock after the load edge, no backpressure. SIM_FAST_TICK_EN forces PRESC=4, STEP_DIV=2.
module dispense_timer
  import dispenser_pkg::*;
#(
  parameter int CLK_HZ   = 50000000,
  parameter int TICK_HZ  = 1,
  parameter int STEP_DIV = 25000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        cmd,
  input  logic [CONT_W-1:0] interval,
  input  logic [CONT_W-1:0] dispense_len,
  output logic [CONT_W-1:0] cont,
  output logic              done,
  output logic              busy,
  output logic              motor_step
);
`ifdef SIM_FAST_TICK_EN
  localparam int PRESC  = 4;
  localparam int STEP_N = 2;
`else
  localparam int PRESC  = CLK_HZ / TICK_HZ;
  localparam int STEP_N = STEP_DIV;
`endif

  state_t            state_q;
  logic [1:0]        cmd_q;
  logic [CONT_W-1:0] cont_q;
  logic              done_q;
  logic              busy_q;
  logic              motor_q;

  logic              load;
  logic [CONT_W-1:0] load_val;
  logic              tick;
  logic              step_tick;

  assign load     = (cmd != cmd_q);
  assign load_val = (cmd == CMD_WAIT) ? interval : dispense_len;

  tick_prescaler #(.PRESC(PRESC)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (load),
    .en    (state_q == ST_COUNT),
    .tick  (tick)
  );

  tick_prescaler #(.PRESC(STEP_N)) u_step (
    .clk   (clk),
    .reset (reset),
    .clr   (load),
    .en    ((state_q == ST_COUNT) && (cmd_q == CMD_DISP)),
    .tick  (step_tick)
  );

  // A load on the same edge as a tick takes priority and swallows that tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cmd_q   <= CMD_IDLE;
      cont_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      motor_q <= 1'b0;
    end else begin
      cmd_q  <= cmd;
      done_q <= 1'b0;
      if (load) begin
        motor_q <= 1'b0;
        if (cmd == CMD_WAIT || cmd == CMD_DISP) begin
          cont_q <= load_val;
          if (load_val == '0) begin
            state_q <= ST_EXPIRED;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_COUNT;
            busy_q  <= 1'b1;
          end
        end else begin
          cont_q  <= '0;
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      end else if (state_q == ST_COUNT) begin
        if (tick && cont_q <= CONT_W'(1)) begin
          cont_q  <= '0;
          done_q  <= 1'b1;
          state_q <= ST_EXPIRED;
          busy_q  <= 1'b0;
          motor_q <= 1'b0;
        end else begin
          if (tick) cont_q <= cont_q - 1'b1;
          if (step_tick) motor_q <= ~motor_q;
        end
      end
    end
  end

  assign cont       = cont_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign motor_step = motor_q;
endmodule

// File: tb/tb_dispense_timer.sv
// Bench for dispense_timer at PRESC=4, STEP_DIV=2, checked every cycle against a
// reference that derives outputs from the load value and clocks elapsed since the load.
module tb_dispense_timer;
  localparam int P = 4;
  localparam int S = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  cmd = 2'b00;
  logic [15:0] interval = '0;
  logic [15:0] dispense_len = '0;
  logic [15:0] cont;
  logic        done;
  logic        busy;
  logic        motor_step;

  int checks = 0;
  int errors = 0;
  bit run_chk = 1'b0;

  dispense_timer #(.CLK_HZ(4), .TICK_HZ(1), .STEP_DIV(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd          (cmd),
    .interval     (interval),
    .dispense_len (dispense_len),
    .cont         (cont),
    .done         (done),
    .busy         (busy),
    .motor_step   (motor_step)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Reference: the phase is the last command seen to change, its loaded value v,
  // and k = clock edges since that load.
  logic [1:0] m_cmd;
  int         m_v;
  int         m_k;
  int         e_cont, e_busy, e_done, e_motor;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cmd = 2'b00;
      m_v   = 0;
      m_k   = 0;
    end else if (cmd != m_cmd) begin
      m_cmd = cmd;
      m_v   = (cmd == 2'b01) ? int'(interval) : (cmd == 2'b10) ? int'(dispense_len) : 0;
      m_k   = 0;
    end else if (m_k < 1000000) begin
      m_k++;
    end
  end

  always_comb begin
    e_cont = 0; e_busy = 0; e_done = 0; e_motor = 0;
    if (!reset && (m_cmd == 2'b01 || m_cmd == 2'b10)) begin
      if (m_v == 0) begin
        e_done = (m_k == 0) ? 1 : 0;
      end else begin
        e_cont  = (m_k / P >= m_v) ? 0 : m_v - m_k / P;
        e_busy  = (e_cont != 0) ? 1 : 0;
        e_done  = (m_k == m_v * P) ? 1 : 0;
        e_motor = (m_cmd == 2'b10 && e_busy == 1) ? (m_k / S) % 2 : 0;
      end
    end
  end

  always @(negedge clk) begin
    if (run_chk) begin
      chk("cont", int'(cont), e_cont);
      chk("busy", int'(busy), e_busy);
      chk("done", int'(done), e_done);
      chk("motor_step", int'(motor_step), e_motor);
    end
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset held two cycles, checked throughout.
    run_chk = 1'b1;
    hold(2);
    reset = 1'b0;
    hold(3);

    // Interval of 3 ticks runs to expiry.
    interval = 16'd3; cmd = 2'b01; hold(16);

    // Switch straight to dispense while the wait count reads 2.
    cmd = 2'b00; hold(1);
    cmd = 2'b01; hold(5);
    dispense_len = 16'd2; cmd = 2'b10; hold(12);

    // Zero-length interval: single done pulse, nothing more while held.
    cmd = 2'b00; hold(2);
    interval = 16'd0; cmd = 2'b01; hold(6);

    // Fault abort at cont=3, then reload from fault.
    cmd = 2'b00; hold(1);
    interval = 16'd5; cmd = 2'b01; hold(9);
    cmd = 2'b11; hold(3);
    cmd = 2'b01; hold(3);

    // Asynchronous reset mid-dispense at cont=7.
    cmd = 2'b00; hold(1);
    dispense_len = 16'd9; cmd = 2'b10; hold(9);
    chk("pre_reset_cont", int'(cont), 7);
    #2 reset = 1'b1;
    #1;
    chk("arst_cont", int'(cont), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_motor", int'(motor_step), 0);
    hold(2);
    reset = 1'b0;
    hold(1);
    chk("reload_after_reset", int'(cont), 9);
    hold(8);

    // Maximum load values count down without wrapping.
    cmd = 2'b00; hold(1);
    interval = 16'hFFFF; cmd = 2'b01; hold(20);
    dispense_len = 16'hFFFF; cmd = 2'b10; hold(20);

    // Random command sequences; load inputs wiggle between loads.
    for (int i = 0; i < 300; i++) begin
      int n;
      cmd = 2'($urandom_range(0, 3));
      interval = 16'($urandom_range(0, 6));
      dispense_len = 16'($urandom_range(0, 6));
      n = $urandom_range(1, 30);
      for (int j = 0; j < n; j++) begin
        hold(1);
        interval = 16'($urandom_range(0, 6));
        dispense_len = 16'($urandom_range(0, 6));
      end
    end

    run_chk = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
